// File: rtl/dport_mux_n_pkg.sv
// dport_mux_n_pkg: shared widths, response record and request/decode helpers for the dport router
package dport_mux_n_pkg;
  localparam int DPORT_TAG_W  = 11;
  localparam int DPORT_ADDR_W = 32;
  localparam int DPORT_DATA_W = 32;
  localparam int DPORT_IDX_W  = 3;
  typedef struct packed {
    logic                    ack;
    logic                    error;
    logic [DPORT_DATA_W-1:0] data;
    logic [DPORT_TAG_W-1:0]  tag;
  } dport_rsp_t;
  function automatic logic req_valid(input logic rd, input logic [3:0] wr, input logic inv,
                                     input logic wb, input logic fl);
    return rd | (|wr) | inv | wb | fl;
  endfunction
  function automatic logic region_match(input logic [DPORT_ADDR_W-1:0] addr,
                                        input logic [DPORT_ADDR_W-1:0] base,
                                        input logic [DPORT_ADDR_W-1:0] mask);
    return (addr & mask) == base;
  endfunction
endpackage

// File: rtl/dport_mux_n_err.sv
// dport_mux_n_err: responder for unmapped addresses, acks with error one cycle after accept and echoes the tag
module dport_mux_n_err
  import dport_mux_n_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_i,
  input  logic [DPORT_TAG_W-1:0] tag_i,
  output logic                   ack_o,
  output logic [DPORT_TAG_W-1:0] tag_o
);
  logic                   ack_d, ack_q;
  logic [DPORT_TAG_W-1:0] tag_d, tag_q;
  // capture the tag of the accepted request and ack it on the following cycle
  always_comb begin
    ack_d = req_i;
    tag_d = req_i ? tag_i : tag_q;
  end
  // response register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_q <= 1'b0;
      tag_q <= '0;
    end else begin
      ack_q <= ack_d;
      tag_q <= tag_d;
    end
  end
  assign ack_o = ack_q;
  assign tag_o = tag_q;
endmodule

// File: rtl/dport_mux_n.sv
// dport_mux_n: address-region router from one dport master to NUM_PORTS slaves with in-order drain (option DPORT_MUX_N_RESP_REG_EN registers the response path)
module dport_mux_n
  import dport_mux_n_pkg::*;
#(
  parameter int                     NUM_PORTS       = 2,
  parameter logic [NUM_PORTS*32-1:0] REGION_BASE    = {32'h80000000, 32'h00000000},
  parameter logic [NUM_PORTS*32-1:0] REGION_MASK    = {32'hF0000000, 32'hFFFC0000},
  parameter int                     FLUSH_PORT      = 1,
  parameter int                     MAX_OUTSTANDING = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [31:0]              mem_addr_i,
  input  logic [31:0]              mem_data_wr_i,
  input  logic                     mem_rd_i,
  input  logic [3:0]               mem_wr_i,
  input  logic                     mem_cacheable_i,
  input  logic [10:0]              mem_req_tag_i,
  input  logic                     mem_invalidate_i,
  input  logic                     mem_writeback_i,
  input  logic                     mem_flush_i,
  output logic [31:0]              mem_data_rd_o,
  output logic                     mem_accept_o,
  output logic                     mem_ack_o,
  output logic                     mem_error_o,
  output logic [10:0]              mem_resp_tag_o,
  output logic [NUM_PORTS*32-1:0]  port_addr_o,
  output logic [NUM_PORTS*32-1:0]  port_data_wr_o,
  output logic [NUM_PORTS-1:0]     port_rd_o,
  output logic [NUM_PORTS*4-1:0]   port_wr_o,
  output logic [NUM_PORTS-1:0]     port_cacheable_o,
  output logic [NUM_PORTS*11-1:0]  port_req_tag_o,
  output logic [NUM_PORTS-1:0]     port_invalidate_o,
  output logic [NUM_PORTS-1:0]     port_writeback_o,
  output logic [NUM_PORTS-1:0]     port_flush_o,
  input  logic [NUM_PORTS-1:0]     port_accept_i,
  input  logic [NUM_PORTS-1:0]     port_ack_i,
  input  logic [NUM_PORTS-1:0]     port_error_i,
  input  logic [NUM_PORTS*32-1:0]  port_data_rd_i,
  input  logic [NUM_PORTS*11-1:0]  port_resp_tag_i
);
  localparam logic [DPORT_IDX_W-1:0] ERR_IDX = DPORT_IDX_W'(NUM_PORTS);
  logic [3:0]             pending_d, pending_q;
  logic [DPORT_IDX_W-1:0] last_tgt_d, last_tgt_q;
  logic [DPORT_IDX_W-1:0] tgt;
  logic                   valid, blocked, accepted, err_req, err_ack;
  logic [DPORT_TAG_W-1:0] err_tag;
  dport_rsp_t             rsp_d;
  assign port_addr_o      = {NUM_PORTS{mem_addr_i}};
  assign port_data_wr_o   = {NUM_PORTS{mem_data_wr_i}};
  assign port_cacheable_o = {NUM_PORTS{mem_cacheable_i}};
  assign port_req_tag_o   = {NUM_PORTS{mem_req_tag_i}};
  // target decode: flush goes to the flush port, else the lowest matching region, else the error responder
  always_comb begin
    tgt = ERR_IDX;
    for (int i = NUM_PORTS - 1; i >= 0; i--)
      if (region_match(mem_addr_i, REGION_BASE[i*32+:32], REGION_MASK[i*32+:32])) tgt = DPORT_IDX_W'(i);
    if (mem_flush_i) tgt = DPORT_IDX_W'(FLUSH_PORT);
  end
  assign valid    = req_valid(mem_rd_i, mem_wr_i, mem_invalidate_i, mem_writeback_i, mem_flush_i);
  assign blocked  = (pending_q != 4'd0 && tgt != last_tgt_q) || pending_q == 4'(MAX_OUTSTANDING);
  assign err_req  = valid && !blocked && tgt == ERR_IDX;
  assign accepted = valid && mem_accept_o;
  // gate strobes to the selected target only and take its accept
  always_comb begin
    port_rd_o         = '0;
    port_wr_o         = '0;
    port_invalidate_o = '0;
    port_writeback_o  = '0;
    port_flush_o      = '0;
    mem_accept_o      = !blocked && tgt == ERR_IDX;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!blocked && tgt == DPORT_IDX_W'(i)) begin
        port_rd_o[i]         = mem_rd_i;
        port_wr_o[i*4+:4]    = mem_wr_i;
        port_invalidate_o[i] = mem_invalidate_i;
        port_writeback_o[i]  = mem_writeback_i;
        port_flush_o[i]      = mem_flush_i;
        mem_accept_o         = port_accept_i[i];
      end
    end
  end
  // response mux keyed by the target that owns the outstanding requests
  always_comb begin
    rsp_d = '{ack: err_ack, error: err_ack, data: '0, tag: err_tag};
    for (int i = 0; i < NUM_PORTS; i++)
      if (last_tgt_q == DPORT_IDX_W'(i))
        rsp_d = '{ack: port_ack_i[i], error: port_error_i[i], data: port_data_rd_i[i*32+:32],
                  tag: port_resp_tag_i[i*11+:11]};
  end
  // outstanding count follows the raw ack so draining is never delayed by the optional output register
  always_comb begin
    pending_d  = pending_q + 4'(accepted) - 4'(rsp_d.ack);
    last_tgt_d = accepted ? tgt : last_tgt_q;
  end
  // tracking state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q  <= '0;
      last_tgt_q <= '0;
    end else begin
      pending_q  <= pending_d;
      last_tgt_q <= last_tgt_d;
    end
  end
  dport_mux_n_err u_err (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i (err_req),
    .tag_i (mem_req_tag_i),
    .ack_o (err_ack),
    .tag_o (err_tag)
  );
`ifdef DPORT_MUX_N_RESP_REG_EN
  dport_rsp_t rsp_q;
  // registered response path
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rsp_q <= '0;
    else       rsp_q <= rsp_d;
  end
  assign mem_ack_o      = rsp_q.ack;
  assign mem_error_o    = rsp_q.error;
  assign mem_data_rd_o  = rsp_q.data;
  assign mem_resp_tag_o = rsp_q.tag;
`else
  assign mem_ack_o      = rsp_d.ack;
  assign mem_error_o    = rsp_d.error;
  assign mem_data_rd_o  = rsp_d.data;
  assign mem_resp_tag_o = rsp_d.tag;
`endif
endmodule

// File: tb/tb_dport_mux_n.sv
// tb_dport_mux_n: directed checks of routing, drain blocking, outstanding limit, error responder, flush and reset
module tb_dport_mux_n;
  logic        clk_i = 1'b0, rst_i = 1'b1;
  logic [31:0] mem_addr_i = '0, mem_data_wr_i = '0;
  logic        mem_rd_i = 1'b0;
  logic [3:0]  mem_wr_i = '0;
  logic        mem_cacheable_i = 1'b0, mem_invalidate_i = 1'b0, mem_writeback_i = 1'b0, mem_flush_i = 1'b0;
  logic [10:0] mem_req_tag_i = '0;
  logic [31:0] mem_data_rd_o;
  logic        mem_accept_o, mem_ack_o, mem_error_o;
  logic [10:0] mem_resp_tag_o;
  logic [63:0] port_addr_o, port_data_wr_o;
  logic [1:0]  port_rd_o, port_cacheable_o, port_invalidate_o, port_writeback_o, port_flush_o;
  logic [7:0]  port_wr_o;
  logic [21:0] port_req_tag_o;
  logic [1:0]  port_accept_i = '0, port_ack_i = '0, port_error_i = '0;
  logic [63:0] port_data_rd_i = '0;
  logic [21:0] port_resp_tag_i = '0;
  int errors = 0, checks = 0;

  dport_mux_n dut (
    .clk_i(clk_i), .rst_i(rst_i), .mem_addr_i(mem_addr_i), .mem_data_wr_i(mem_data_wr_i),
    .mem_rd_i(mem_rd_i), .mem_wr_i(mem_wr_i), .mem_cacheable_i(mem_cacheable_i),
    .mem_req_tag_i(mem_req_tag_i), .mem_invalidate_i(mem_invalidate_i),
    .mem_writeback_i(mem_writeback_i), .mem_flush_i(mem_flush_i), .mem_data_rd_o(mem_data_rd_o),
    .mem_accept_o(mem_accept_o), .mem_ack_o(mem_ack_o), .mem_error_o(mem_error_o),
    .mem_resp_tag_o(mem_resp_tag_o), .port_addr_o(port_addr_o), .port_data_wr_o(port_data_wr_o),
    .port_rd_o(port_rd_o), .port_wr_o(port_wr_o), .port_cacheable_o(port_cacheable_o),
    .port_req_tag_o(port_req_tag_o), .port_invalidate_o(port_invalidate_o),
    .port_writeback_o(port_writeback_o), .port_flush_o(port_flush_o), .port_accept_i(port_accept_i),
    .port_ack_i(port_ack_i), .port_error_i(port_error_i), .port_data_rd_i(port_data_rd_i),
    .port_resp_tag_i(port_resp_tag_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (dut.pending_q !== 4'd0) begin errors++; $display("FAIL reset_pending: got %0d want 0", dut.pending_q); end
    checks++; if (mem_ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", mem_ack_o); end
    checks++; if (port_rd_o !== 2'b00) begin errors++; $display("FAIL reset_port_rd: got %b want 00", port_rd_o); end
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_read();
    mem_rd_i = 1'b1; mem_addr_i = 32'h0000_0100; port_accept_i = 2'b01;
    #1;
    checks++; if (mem_accept_o !== 1'b1) begin errors++; $display("FAIL rd_accept: got %b want 1", mem_accept_o); end
    checks++; if (port_rd_o !== 2'b01) begin errors++; $display("FAIL rd_port: got %b want 01", port_rd_o); end
    tick();
    mem_rd_i = 1'b0;
    checks++; if (dut.pending_q !== 4'd1) begin errors++; $display("FAIL rd_pending1: got %0d want 1", dut.pending_q); end
    tick();
    port_ack_i = 2'b01; port_data_rd_i[31:0] = 32'hDEAD_BEEF;
    #1;
    checks++; if (mem_ack_o !== 1'b1) begin errors++; $display("FAIL rd_ack: got %b want 1", mem_ack_o); end
    checks++; if (mem_data_rd_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data: got %h want deadbeef", mem_data_rd_o); end
    checks++; if (mem_error_o !== 1'b0) begin errors++; $display("FAIL rd_error: got %b want 0", mem_error_o); end
    tick();
    port_ack_i = 2'b00;
    checks++; if (dut.pending_q !== 4'd0) begin errors++; $display("FAIL rd_pending0: got %0d want 0", dut.pending_q); end
  endtask

  task automatic test_switch_block();
    mem_rd_i = 1'b1; mem_addr_i = 32'h0000_0040; port_accept_i = 2'b11;
    tick();
    mem_addr_i = 32'h8000_0000;
    #1;
    checks++; if (mem_accept_o !== 1'b0) begin errors++; $display("FAIL sw_block_accept: got %b want 0", mem_accept_o); end
    checks++; if (port_rd_o !== 2'b00) begin errors++; $display("FAIL sw_block_rd: got %b want 00", port_rd_o); end
    tick();
    port_ack_i = 2'b01;
    #1;
    checks++; if (mem_accept_o !== 1'b0) begin errors++; $display("FAIL sw_ackcycle_accept: got %b want 0", mem_accept_o); end
    tick();
    port_ack_i = 2'b00;
    #1;
    checks++; if (mem_accept_o !== 1'b1) begin errors++; $display("FAIL sw_release_accept: got %b want 1", mem_accept_o); end
    checks++; if (port_rd_o !== 2'b10) begin errors++; $display("FAIL sw_release_rd: got %b want 10", port_rd_o); end
    tick();
    mem_rd_i = 1'b0;
    port_ack_i = 2'b01;
    #1;
    checks++; if (mem_ack_o !== 1'b0) begin errors++; $display("FAIL sw_foreign_ack: got %b want 0", mem_ack_o); end
    tick();
    checks++; if (dut.pending_q !== 4'd1) begin errors++; $display("FAIL sw_foreign_pending: got %0d want 1", dut.pending_q); end
    port_ack_i = 2'b10; port_data_rd_i[63:32] = 32'h1234_5678; port_resp_tag_i[21:11] = 11'h055;
    #1;
    checks++; if (mem_ack_o !== 1'b1) begin errors++; $display("FAIL sw_p1_ack: got %b want 1", mem_ack_o); end
    checks++; if (mem_data_rd_o !== 32'h1234_5678) begin errors++; $display("FAIL sw_p1_data: got %h want 12345678", mem_data_rd_o); end
    checks++; if (mem_resp_tag_o !== 11'h055) begin errors++; $display("FAIL sw_p1_tag: got %h want 055", mem_resp_tag_o); end
    tick();
    port_ack_i = 2'b00;
    checks++; if (dut.pending_q !== 4'd0) begin errors++; $display("FAIL sw_pending0: got %0d want 0", dut.pending_q); end
  endtask

  task automatic test_max_outstanding();
    mem_rd_i = 1'b1; mem_addr_i = 32'h0000_0200; port_accept_i = 2'b01;
    tick(); tick(); tick();
    checks++; if (dut.pending_q !== 4'd3) begin errors++; $display("FAIL max_pending3: got %0d want 3", dut.pending_q); end
    port_ack_i = 2'b01;
    #1;
    checks++; if (mem_accept_o !== 1'b1) begin errors++; $display("FAIL max_acc_with_ack: got %b want 1", mem_accept_o); end
    tick();
    checks++; if (dut.pending_q !== 4'd3) begin errors++; $display("FAIL max_ack_and_req: got %0d want 3", dut.pending_q); end
    port_ack_i = 2'b00;
    tick();
    checks++; if (dut.pending_q !== 4'd4) begin errors++; $display("FAIL max_pending4: got %0d want 4", dut.pending_q); end
    checks++; if (mem_accept_o !== 1'b0) begin errors++; $display("FAIL max_stall_accept: got %b want 0", mem_accept_o); end
    checks++; if (port_rd_o !== 2'b00) begin errors++; $display("FAIL max_stall_rd: got %b want 00", port_rd_o); end
    port_ack_i = 2'b01;
    tick();
    checks++; if (dut.pending_q !== 4'd3) begin errors++; $display("FAIL max_ack_while_full: got %0d want 3", dut.pending_q); end
    mem_rd_i = 1'b0;
    tick(); tick(); tick();
    port_ack_i = 2'b00;
    checks++; if (dut.pending_q !== 4'd0) begin errors++; $display("FAIL max_drain: got %0d want 0", dut.pending_q); end
  endtask

  task automatic test_unmapped();
    mem_wr_i = 4'hF; mem_addr_i = 32'h4000_0000; mem_req_tag_i = 11'h2A5; port_accept_i = 2'b00;
    #1;
    checks++; if (mem_accept_o !== 1'b1) begin errors++; $display("FAIL err_accept: got %b want 1", mem_accept_o); end
    checks++; if (port_wr_o !== 8'h00) begin errors++; $display("FAIL err_port_wr: got %h want 00", port_wr_o); end
    tick();
    mem_wr_i = 4'h0; mem_req_tag_i = 11'h000;
    checks++; if (mem_ack_o !== 1'b1) begin errors++; $display("FAIL err_ack: got %b want 1", mem_ack_o); end
    checks++; if (mem_error_o !== 1'b1) begin errors++; $display("FAIL err_error: got %b want 1", mem_error_o); end
    checks++; if (mem_resp_tag_o !== 11'h2A5) begin errors++; $display("FAIL err_tag: got %h want 2a5", mem_resp_tag_o); end
    checks++; if (mem_data_rd_o !== 32'h0) begin errors++; $display("FAIL err_data: got %h want 0", mem_data_rd_o); end
    tick();
    checks++; if (mem_ack_o !== 1'b0) begin errors++; $display("FAIL err_ack_clear: got %b want 0", mem_ack_o); end
    checks++; if (dut.pending_q !== 4'd0) begin errors++; $display("FAIL err_pending0: got %0d want 0", dut.pending_q); end
  endtask

  task automatic test_flush();
    mem_flush_i = 1'b1; mem_addr_i = 32'h0000_0000; port_accept_i = 2'b10;
    #1;
    checks++; if (port_flush_o !== 2'b10) begin errors++; $display("FAIL flush_port: got %b want 10", port_flush_o); end
    checks++; if (mem_accept_o !== 1'b1) begin errors++; $display("FAIL flush_accept: got %b want 1", mem_accept_o); end
    tick();
    mem_flush_i = 1'b0;
    port_ack_i = 2'b10;
    tick();
    port_ack_i = 2'b00;
    checks++; if (dut.pending_q !== 4'd0) begin errors++; $display("FAIL flush_pending0: got %0d want 0", dut.pending_q); end
  endtask

  task automatic test_reset_mid();
    mem_rd_i = 1'b1; mem_addr_i = 32'h0000_0300; port_accept_i = 2'b01;
    tick(); tick(); tick();
    mem_rd_i = 1'b0;
    checks++; if (dut.pending_q !== 4'd3) begin errors++; $display("FAIL rstmid_pending3: got %0d want 3", dut.pending_q); end
    rst_i = 1'b1;
    #1;
    checks++; if (dut.pending_q !== 4'd0) begin errors++; $display("FAIL rstmid_pending0: got %0d want 0", dut.pending_q); end
    checks++; if (mem_ack_o !== 1'b0) begin errors++; $display("FAIL rstmid_ack: got %b want 0", mem_ack_o); end
    tick();
    rst_i = 1'b0;
    mem_rd_i = 1'b1; mem_addr_i = 32'h8000_0010; port_accept_i = 2'b10;
    #1;
    checks++; if (mem_accept_o !== 1'b1) begin errors++; $display("FAIL rstmid_new_accept: got %b want 1", mem_accept_o); end
    checks++; if (port_rd_o !== 2'b10) begin errors++; $display("FAIL rstmid_new_rd: got %b want 10", port_rd_o); end
    tick();
    mem_rd_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_read();
    test_switch_block();
    test_max_outstanding();
    test_unmapped();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
